uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 258 +++++++++++++++++++++++++
 tb/tb_uart_rx.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : 8N1 UART receiver with a single-entry holding register.
//
// Optional feature macro: UART_RX_PARITY_EN
//   When it is defined, the frame carries one even-parity bit after the data
//   bits and the parity_err_o port is present. When it is undefined, the frame
//   is start + 8 data + stop and the port does not exist.
//
// Parameters
//   CLOCK        input clock frequency in Hz
//   BAUD_RATE    line bit rate
//   BAUD_COUNTER clocks per bit (minimum 4)
//
// Ports
//   clk_i         clock; all logic runs on the rising edge
//   rst_ni        synchronous active-low reset
//   rx_i          asynchronous serial line, idle high
//   rx_data_o     received byte, valid while rx_valid_o = 1
//   rx_valid_o    holding register full
//   rx_ready_i    consumer accepts the byte when rx_valid_o & rx_ready_i
//   frame_err_o   one-cycle pulse: stop bit sampled low
//   overrun_err_o one-cycle pulse: completed byte dropped, holding register full
//   parity_err_o  one-cycle pulse with byte completion on parity mismatch
//                 (UART_RX_PARITY_EN only)
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter real CLOCK        = 100e6,
    parameter int  BAUD_RATE    = 20000000,
    parameter int  BAUD_COUNTER = $rtoi(CLOCK / BAUD_RATE)
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       frame_err_o,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err_o,
`endif
    output logic       overrun_err_o
);

    localparam int TW = $clog2(BAUD_COUNTER + 1);

    // Terminal counts: the start bit is resampled half a bit in, every later
    // bit one full bit period after the previous sample.
    localparam logic [TW-1:0] HALF_LAST = TW'(BAUD_COUNTER / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(BAUD_COUNTER - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_e;
`else
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_e;
`endif

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;

    // Synchronizer pair plus one history flop for the falling-edge detect.
    logic            rx_meta_q, rx_sync_q, rx_prev_q;

    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;
    logic            complete;

`ifdef UART_RX_PARITY_EN
    logic            par_bit_q, par_bit_d;
    logic            perr_q, perr_d;
`endif

    // -----------------------------------------------------------------------
    // Frame sequencing
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        ferr_d   = 1'b0;
        complete = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d = par_bit_q;
`endif

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = START;
                end
            end

            START: begin
                if (timer_q == HALF_LAST) begin
                    timer_d = '0;
                    if (rx_sync_q) begin
                        state_d = IDLE;          // glitch, not a real start bit
                    end else begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            DATA: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};   // LSB arrives first
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (timer_q == BIT_LAST) begin
                    timer_d   = '0;
                    par_bit_d = rx_sync_q;
                    state_d   = STOP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
`endif

            STOP: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    if (rx_sync_q) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            WAIT_IDLE: begin
                timer_d = '0;
                if (rx_sync_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Holding register and handshake
    // -----------------------------------------------------------------------
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;

        if (complete) begin
            // A completion coinciding with an accepting handshake replaces
            // the consumed byte without ever dropping rx_valid_o.
            if (!valid_q || rx_ready_i) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_ready_i) begin
            valid_d = 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_comb begin
        perr_d = complete && ((^shift_q) != par_bit_q);
    end
`endif

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q <= par_bit_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign rx_data_o     = data_q;
    assign rx_valid_o    = valid_q;
    assign frame_err_o   = ferr_q;
    assign overrun_err_o = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o  = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx : directed self-checking bench for uart_rx (5 clocks per bit).
// A frame-level model predicts one event per frame (byte / frame error /
// overrun) into a queue; a negedge compare process matches DUT pulses and
// byte presentations against that queue and checks held data stays stable.
// Define UART_RX_PARITY_EN to build the parity variant.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int BC = 5;

    localparam int EV_BYTE = 0;
    localparam int EV_FERR = 1;
    localparam int EV_OVR  = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic       perr;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       ovr;
`ifdef UART_RX_PARITY_EN
    logic       perr;
`endif

    ev_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic model_full = 1'b0;

    always #5 clk = ~clk;

    uart_rx #(
        .CLOCK     (100e6),
        .BAUD_RATE (20000000)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .rx_i          (rx),
        .rx_data_o     (data),
        .rx_valid_o    (valid),
        .rx_ready_i    (ready),
        .frame_err_o   (ferr),
`ifdef UART_RX_PARITY_EN
        .parity_err_o  (perr),
`endif
        .overrun_err_o (ovr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Match one observed DUT event against the head of the expectation queue.
    task automatic observe(input int kind, input logic [7:0] d, input logic pe);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d data %0h, expected nothing (t=%0t)",
                     kind, d, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == EV_BYTE && (e.data !== d || e.perr !== pe))) begin
                errors++;
                $display("FAIL event: got kind %0d data %0h perr %0b, expected kind %0d data %0h perr %0b (t=%0t)",
                         kind, d, pe, e.kind, e.data, e.perr, $time);
            end
        end
    endtask

    // Frame-level model: decides the outcome of a frame from its stop bit,
    // holding-register occupancy and the ready level at completion.
    task automatic model_frame(input logic [7:0] b, input logic stop_b,
                               input logic rdy, input logic par_b);
        ev_t e;
        e.data = b;
        e.perr = 1'b0;
`ifdef UART_RX_PARITY_EN
        e.perr = ((^b) != par_b);
`endif
        if (!stop_b) begin
            e.kind = EV_FERR;
            exp_q.push_back(e);
        end else if (model_full && !rdy) begin
            e.kind = EV_OVR;
            exp_q.push_back(e);
        end else begin
            e.kind = EV_BYTE;
            exp_q.push_back(e);
            model_full = !rdy;
        end
    endtask

    // Drive one frame; late_ready raises rx_ready_i in the last clock of the
    // stop bit so the handshake coincides with the completion.
    task automatic send_frame(input logic [7:0] b, input logic stop_b, input int hold_low,
                              input logic late_ready, input logic par_b);
        model_frame(b, stop_b, late_ready | ready, par_b);
        rx = 1'b0;
        tick(BC);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(BC);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_b;
        tick(BC);
`endif
        rx = stop_b;
        if (late_ready) begin
            tick(BC - 1);
            ready = 1'b1;
            tick(1);
        end else begin
            tick(BC);
        end
        if (!stop_b) begin
            tick(hold_low);
            rx = 1'b1;
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    // Compare process
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [7:0] pd = '0;
    logic       pe_now;

    always @(negedge clk) begin
        pe_now = 1'b0;
`ifdef UART_RX_PARITY_EN
        pe_now = perr;
`endif
        if (rst_n === 1'b1) begin
            if (ferr) observe(EV_FERR, 8'h00, 1'b0);
            if (ovr) begin
                observe(EV_OVR, 8'h00, 1'b0);
                chk("ovr_valid", valid, 1'b1);
            end
            if (valid && (!pv || pr)) begin
                observe(EV_BYTE, data, pe_now);
            end else begin
                if (valid && pv && !pr) chk("hold_data", data, pd);
                if (pe_now) chk("stray_parity_err", pe_now, 1'b0);
            end
            pv = valid;
            pr = ready;
            pd = data;
        end else begin
            pv = 1'b0;
            pr = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] fb;
        rst_n = 1'b0;
        rx    = 1'b1;
        ready = 1'b1;
        tick(3);
        chk("rst_data",  data,  8'h00);
        chk("rst_valid", valid, 1'b0);
        chk("rst_ferr",  ferr,  1'b0);
        chk("rst_ovr",   ovr,   1'b0);
        rst_n = 1'b1;
        tick(5);

        // Clean frame, consumer always ready: one-cycle valid right after stop.
        send_frame(8'hA5, 1'b1, 0, 1'b0, 1'b0);
        chk("a5_valid_at_stop", valid, 1'b1);
        chk("a5_data", data, 8'hA5);
        tick(1);
        chk("a5_valid_one_cycle", valid, 1'b0);
        wait_drain("a5_drain", 20);
        tick(5);

        // Two-clock glitch is rejected; next frame still decoded.
        rx = 1'b0;
        tick(2);
        rx = 1'b1;
        tick(12);
        chk("glitch_no_valid", valid, 1'b0);
        send_frame(8'h3C, 1'b1, 0, 1'b0, 1'b0);
        wait_drain("3c_drain", 20);
        tick(5);

        // Stop bit low with line held low: exactly one frame error.
        send_frame(8'h55, 1'b0, 30, 1'b0, 1'b0);
        tick(10);
        send_frame(8'h81, 1'b1, 0, 1'b0, 1'b0);
        wait_drain("ferr_81_drain", 20);
        tick(5);

        // Back-to-back frames with consumer stalled: overrun keeps first byte.
        ready = 1'b0;
        send_frame(8'h11, 1'b1, 0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 0, 1'b0, 1'b0);
        wait_drain("ovr_drain", 20);
        tick(5);
        chk("ovr_held_data",  data,  8'h11);
        chk("ovr_held_valid", valid, 1'b1);
        ready = 1'b1;
        model_full = 1'b0;
        tick(1);
        chk("accept_clears_valid", valid, 1'b0);
        tick(5);

        // Completion in the same cycle as the accepting handshake: no overrun.
        ready = 1'b0;
        send_frame(8'h44, 1'b1, 0, 1'b0, 1'b0);
        send_frame(8'h66, 1'b1, 0, 1'b1, 1'b0);
        wait_drain("handshake_drain", 20);
        chk("handshake_new_data", data, 8'h66);
        tick(5);

        // Reset during data bit 4 of 0xF0; the rest of the frame is ignored.
        fb = 8'hF0;
        rx = 1'b0;
        tick(BC);
        for (int i = 0; i < 4; i++) begin
            rx = fb[i];
            tick(BC);
        end
        rx = fb[4];
        tick(2);
        rst_n = 1'b0;
        tick(2);
        chk("midrst_data",  data,  8'h00);
        chk("midrst_valid", valid, 1'b0);
        chk("midrst_ferr",  ferr,  1'b0);
        chk("midrst_ovr",   ovr,   1'b0);
        rst_n = 1'b1;
        tick(1);
        for (int i = 5; i < 8; i++) begin
            rx = fb[i];
            tick(BC);
        end
        rx = 1'b1;
        tick(BC + 10);
        chk("midrst_no_valid", valid, 1'b0);
        send_frame(8'h0F, 1'b1, 0, 1'b0, 1'b0);
        wait_drain("0f_drain", 20);
        chk("0f_data", data, 8'h0F);
        tick(5);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: parity 0 is a mismatch, parity 1 is correct.
        send_frame(8'h07, 1'b1, 0, 1'b0, 1'b0);
        chk("par_bad_valid", valid, 1'b1);
        chk("par_bad_flag",  perr,  1'b1);
        wait_drain("par_bad_drain", 20);
        tick(5);
        send_frame(8'h07, 1'b1, 0, 1'b0, 1'b1);
        chk("par_ok_flag", perr, 1'b0);
        wait_drain("par_ok_drain", 20);
        tick(5);
`endif

        chk("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
